router_ingress: RTL and testbench

Input stage of the 1x3 router: accepts byte-serial packets from the source side (`data_in`, `pkt_valid`) and decodes the header address. It steers header, payload and parity bytes into one of three destination FIFOs and back-pressures the source with `busy`. It accumulates parity and flags `error` on parity (and optionally length) mismatch. Packet format: header byte `{len[5:0], addr[1:0]}`, `len` payload bytes, one parity byte (XOR of header and payload).

---
 rtl/router_pkg.sv | 49 ++++
 rtl/router_parity_acc.sv | 31 +++
 rtl/router_ingress.sv | 137 +++++++++++++
 tb/tb_router_ingress.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1x3 router.
//   - state_e      : ingress FSM states
//   - ADDR_INVALID : header address that selects no destination (packet dropped)
//   - NUM_DEST     : number of destination FIFOs
//   - hdr_t        : header byte layout {len, addr}
//   - helpers      : header field extraction and address one-hot decode
package router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_DATA,
        DROP,
        CHECK_PARITY
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam int         NUM_DEST     = 3;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = HDR_ADDR_LSB + HDR_ADDR_W;
    localparam int HDR_LEN_W    = 6;
    localparam int HDR_W        = HDR_LEN_W + HDR_ADDR_W;

    typedef struct packed {
        logic [HDR_LEN_W-1:0]  len;
        logic [HDR_ADDR_W-1:0] addr;
    } hdr_t;

    function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [HDR_W-1:0] b);
        hdr_t h;
        h = hdr_t'(b);
        return h.addr;
    endfunction

    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [HDR_W-1:0] b);
        hdr_t h;
        h = hdr_t'(b);
        return h.len;
    endfunction

    // ADDR_INVALID decodes to all-zero, so it never selects a FIFO.
    function automatic logic [NUM_DEST-1:0] addr_onehot(input logic [HDR_ADDR_W-1:0] a);
        logic [NUM_DEST-1:0] oh;
        for (int i = 0; i < NUM_DEST; i++) oh[i] = (int'(a) == i);
        return oh;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: byte-wide XOR accumulator.
//   clock/resetn : clock, async active-low reset
//   load         : restart accumulation with din
//   accum        : fold din into the running parity
//   din          : byte to load/accumulate
//   cmp_val      : received parity to compare against
//   parity       : running parity
//   mismatch     : parity != cmp_val (combinational)
// Also reused by the FIFO read-side checker, so it carries no packet framing.
module router_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic              accum,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] cmp_val,
    output logic [DATA_W-1:0] parity,
    output logic              mismatch
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     parity <= '0;
        else if (load)   parity <= din;
        else if (accum)  parity <= parity ^ din;
    end

    assign mismatch = (parity != cmp_val);

endmodule

// File: rtl/router_ingress.sv
// router_ingress: input stage of the 1x3 router.
//   clock, resetn : clock, async active-low reset
//   data_in       : packet byte from source
//   pkt_valid     : high for header+payload; first low cycle carries parity
//   fifo_full     : per-destination full flags
//   busy          : source must hold data_in/pkt_valid while high
//   error         : last packet bad; held until next header is accepted
//   pkt_done      : one-cycle pulse per completed packet
//   wr_en/wr_data : one-hot FIFO write strobe and data (same cycle as data_in)
// Optional: define ROUTER_INGRESS_LEN_CHECK_EN to also flag payload count != len.
import router_pkg::*;

module router_ingress #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                pkt_valid,
    input  logic [NUM_DEST-1:0] fifo_full,
    output logic                busy,
    output logic                error,
    output logic                pkt_done,
    output logic [NUM_DEST-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data
);

    localparam int HDR_BITS = LEN_W + HDR_ADDR_W;

    state_e                  state_q, state_d;
    logic [HDR_ADDR_W-1:0]   hdr_a, addr_q;
    logic                    drop_q;
    logic [DATA_W-1:0]       rx_par_q;
    logic [DATA_W-1:0]       par_acc;
    logic                    par_bad, len_bad, bad;
    logic                    accept, hdr_take, body_take, rx_take;
    logic [NUM_DEST-1:0]     dest_oh;

    assign hdr_a = hdr_addr(data_in[HDR_BITS-1:0]);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        accept  = 1'b0;
        dest_oh = '0;
        case (state_q)
            IDLE: if (pkt_valid) begin
                dest_oh = addr_onehot(hdr_a);
                busy    = |(fifo_full & dest_oh);
                accept  = !busy;
                if (accept) state_d = (hdr_a == ADDR_INVALID) ? DROP : LOAD_DATA;
            end
            LOAD_DATA: begin
                dest_oh = addr_onehot(addr_q);
                busy    = |(fifo_full & dest_oh);
                accept  = !busy;
                if (accept && !pkt_valid) state_d = CHECK_PARITY;
            end
            DROP: begin
                accept = 1'b1;
                if (!pkt_valid) state_d = CHECK_PARITY;
            end
            CHECK_PARITY: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // dest_oh is zero in DROP and for an invalid header, so those never write.
    assign wr_en   = accept ? dest_oh : '0;
    assign wr_data = data_in;

    assign hdr_take  = accept && (state_q == IDLE);
    assign body_take = accept && (state_q == LOAD_DATA || state_q == DROP);
    assign rx_take   = body_take && !pkt_valid;

    router_parity_acc #(.DATA_W(DATA_W)) u_par (
        .clock    (clock),
        .resetn   (resetn),
        .load     (hdr_take),
        .accum    (body_take && pkt_valid),
        .din      (data_in),
        .cmp_val  (rx_par_q),
        .parity   (par_acc),
        .mismatch (par_bad)
    );

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
    localparam int CNT_W = LEN_W + 1;
    logic [CNT_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;

    // Extra bit lets an over-long payload be seen as a mismatch; saturate at all-ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            len_q   <= '0;
        end else if (hdr_take) begin
            count_q <= '0;
            len_q   <= hdr_len(data_in[HDR_BITS-1:0]);
        end else if (state_q == LOAD_DATA && body_take && pkt_valid && count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign len_bad = (count_q != {1'b0, len_q});
`else
    assign len_bad = 1'b0;
`endif

    assign bad = par_bad | drop_q | len_bad;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            drop_q   <= 1'b0;
            rx_par_q <= '0;
            error    <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            pkt_done <= (state_q == CHECK_PARITY);
            if (hdr_take) begin
                addr_q <= hdr_a;
                drop_q <= (hdr_a == ADDR_INVALID);
                error  <= 1'b0;
            end
            if (rx_take) rx_par_q <= data_in;
            if (state_q == CHECK_PARITY) error <= bad;
        end
    end

endmodule

// File: tb/tb_router_ingress.sv
// tb_router_ingress: randomized + directed packet bench for router_ingress.
// The reference works per packet: expected busy/wr_en from the destination's
// full flag, expected error from XOR over the header+payload and the address.
module tb_router_ingress;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic [2:0] fifo_full;
    logic       busy, error, pkt_done;
    logic [2:0] wr_en;
    logic [7:0] wr_data;

    router_ingress dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .fifo_full (fifo_full),
        .busy      (busy),
        .error     (error),
        .pkt_done  (pkt_done),
        .wr_en     (wr_en),
        .wr_data   (wr_data)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] pkt_q[$];
    logic       pend_done = 1'b0, pend_err = 1'b0, chk_low = 1'b0, chk_clr = 1'b0;
    int         stall_left = 0, n_busy = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Deferred checks: pkt_done/error one cycle after CHECK_PARITY, pulse width,
    // and error cleared after a header is accepted.
    task automatic post_checks();
        if (chk_low) begin
            check("pkt_done_pulse", 32'(pkt_done), 32'd0);
            chk_low = 1'b0;
        end
        if (pend_done) begin
            check("pkt_done", 32'(pkt_done), 32'd1);
            check("error", 32'(error), 32'(pend_err));
            pend_done = 1'b0;
            chk_low   = 1'b1;
        end
        if (chk_clr) begin
            check("error_clr", 32'(error), 32'd0);
            chk_clr = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pkt_valid = 1'b0;
            data_in   = 8'($urandom);
            fifo_full = 3'($urandom);
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_wr", 32'(wr_en), 32'd0);
            post_checks();
        end
    endtask

    // Drives pkt_q (header, payload..., parity) honoring busy; stops early at stop_at.
    task automatic send_pkt(input int stall_pct, input int stop_at);
        int         n = pkt_q.size();
        int         idx = 0, guard = 0, nwr = 0;
        logic [1:0] a = pkt_q[0][1:0];
        logic [7:0] par = 8'h00;
        logic       exp_b, exp_err;
        logic [2:0] exp_w;
        for (int i = 0; i < n - 1; i++) par ^= pkt_q[i];
        exp_err = (par != pkt_q[n-1]) || (a == 2'd3);
`ifdef ROUTER_INGRESS_LEN_CHECK_EN
        if ((n - 2) != int'(pkt_q[0][7:2])) exp_err = 1'b1;
`endif
        n_busy = 0;
        while (idx < stop_at && guard < 2000) begin
            guard++;
            @(negedge clock);
            data_in   = pkt_q[idx];
            pkt_valid = (idx != n - 1);
            if (stall_left > 0 && idx == 2) begin
                fifo_full = 3'b100;
                stall_left--;
            end else begin
                for (int k = 0; k < 3; k++) fifo_full[k] = ($urandom_range(0, 99) < stall_pct);
            end
            #1;
            exp_b = (a == 2'd3) ? 1'b0 : fifo_full[a];
            exp_w = (exp_b || a == 2'd3) ? 3'b000 : 3'(3'b001 << a);
            check("busy", 32'(busy), 32'(exp_b));
            check("wr_en", 32'(wr_en), 32'(exp_w));
            if (exp_w != 3'b000) check("wr_data", 32'(wr_data), 32'(pkt_q[idx]));
            if (wr_en != 3'b000) nwr++;
            if (busy) n_busy++;
            post_checks();
            if (!busy) begin
                if (idx == 0) chk_clr = 1'b1;
                idx++;
            end
        end
        if (idx < stop_at) check("timeout", 32'd0, 32'd1);
        if (stop_at < n) return;
        @(negedge clock);
        pkt_valid = 1'b0;
        data_in   = 8'($urandom);
        fifo_full = 3'($urandom);
        #1;
        check("chk_busy", 32'(busy), 32'd1);
        check("chk_wr", 32'(wr_en), 32'd0);
        post_checks();
        check("n_writes", 32'(nwr), (a == 2'd3) ? 32'd0 : 32'(n));
        pend_done = 1'b1;
        pend_err  = exp_err;
    endtask

    task automatic load_pkt(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input int np, input logic [7:0] par);
        pkt_q.delete();
        pkt_q.push_back(h);
        if (np > 0) pkt_q.push_back(p0);
        if (np > 1) pkt_q.push_back(p1);
        if (np > 2) pkt_q.push_back(p2);
        pkt_q.push_back(par);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ra;
        int         rlen, plen;
        logic [7:0] rpar, rb;

        resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
        @(negedge clock); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr", 32'(wr_en), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_done", 32'(pkt_done), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        idle(1);

        // good packet
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        send_pkt(0, pkt_q.size());
        idle(2);

        // bad parity, then a good packet back-to-back (error must clear)
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0C);
        send_pkt(0, pkt_q.size());
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        send_pkt(0, pkt_q.size());
        idle(2);

        // stall: fifo 2 full for 3 cycles on the second payload byte
        load_pkt(8'h0A, 8'h5A, 8'hA5, 8'h00, 2, 8'hF5);
        stall_left = 3;
        send_pkt(0, pkt_q.size());
        check("stall_busy_cycles", 32'(n_busy), 32'd3);
        idle(2);

        // invalid address, random full flags must not matter
        load_pkt(8'h0B, 8'h01, 8'h02, 8'h00, 2, 8'h08);
        send_pkt(50, pkt_q.size());
        idle(2);

        // length mismatch with correct parity
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h00, 2, 8'h3E);
        send_pkt(0, pkt_q.size());
        idle(2);

        // reset after the second payload byte
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        send_pkt(0, 3);
        @(negedge clock);
        pkt_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr", 32'(wr_en), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_done", 32'(pkt_done), 32'd0);
        pend_done = 1'b0; chk_low = 1'b0; chk_clr = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        load_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 3, 8'h0D);
        send_pkt(0, pkt_q.size());
        idle(2);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            ra   = 2'($urandom_range(0, 3));
            rlen = $urandom_range(0, 8);
            plen = rlen;
            if ($urandom_range(0, 7) == 0) plen = rlen + 1;
            else if (rlen > 0 && $urandom_range(0, 7) == 0) plen = rlen - 1;
            pkt_q.delete();
            rpar = {6'(rlen), ra};
            pkt_q.push_back(rpar);
            for (int k = 0; k < plen; k++) begin
                rb = 8'($urandom);
                pkt_q.push_back(rb);
                rpar ^= rb;
            end
            if ($urandom_range(0, 3) == 0) rpar ^= 8'(1 << $urandom_range(0, 7));
            pkt_q.push_back(rpar);
            send_pkt(30, pkt_q.size());
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
